od_pulse_receiver: RTL and testbench
====================================

// Module: od_pulse_receiver
// PURPOSE
// Receive end of the open-drain single-wire link that the pulled-up bufif0 drivers produce.
// - Samples the wired line, synchronises it and filters glitches.
// - Decodes low-pulse widths into bits, assembles words and delivers them over a valid/ready port.
// - Flags framing errors, overruns and bus-reset pulses.
// - Sits between the pad-level line and the register/control logic.
// PARAMETERS
// DATA_W      8   bits per word, LSB first on the line
// FILT        3   consecutive equal synced samples required to change filtered level (>=1)
// T_ONE_MAX   8   low width <= this (cycles) decodes as bit 1
// T_ZERO_MAX  32  low width in (T_ONE_MAX, T_ZERO_MAX] decodes as bit 0
// T_RESET_MIN 64  low width reaching this is a bus reset (> T_ZERO_MAX)
// T_IDLE      48  high width reaching this with a partial word aborts the frame
// PORTS
// clk          in   1       single clock, all logic rising-edge
// rst          in   1       synchronous, active-high reset
// line_i       in   1       raw wired line (pulled up; low = driven)
// m_data_o     out  DATA_W  received word
// m_valid_o    out  1       m_data_o holds an unconsumed word
// m_ready_i    in   1       consumer accepts word when m_valid_o & m_ready_i
// frame_err_o  out  1       1-cycle pulse: bad pulse width or idle timeout mid-word
// overrun_o    out  1       1-cycle pulse: completed word dropped, holding reg full
// bus_reset_o  out  1       1-cycle pulse: low width reached T_RESET_MIN
// line_lvl_o   out  1       filtered line level
// busy_o       out  1       state != IDLE or bit count != 0
// BEHAVIOUR
// Reset:
// - sync flops, line_lvl_o = 1; m_data_o = 0; m_valid_o, frame_err_o, overrun_o, bus_reset_o, busy_o = 0.
// - FSM = IDLE; bit count, width counter and shift register cleared.
// - A mid-frame reset discards the partial word and any held word.
// Front end:
// - line_i -> s1 -> s2 (two flops).
// - line_lvl_o flips on the cycle the FILT-th consecutive s2 sample differing from it is registered.
// - Any s2 sample equal to line_lvl_o clears the run count.
// - Edge latency is 2+FILT cycles.
// Width counter:
// - Clears on every filtered edge, increments each cycle, saturates at max(T_RESET_MIN, T_IDLE).
// - Width = cycles line_lvl_o stayed at a level.
// FSM:
// - IDLE: filtered fall -> LOW.
// - LOW, filtered rise with width w:
//   - w <= T_ONE_MAX: shift in 1.
//   - w <= T_ZERO_MAX: shift in 0.
//   - Either case -> GAP.
//   - Else: frame_err_o pulse, clear word -> IDLE.
// - LOW, width reaches T_RESET_MIN: bus_reset_o pulse on that cycle, clear word -> RST.
// - RST: filtered rise -> IDLE. No further pulses while held low.
// - GAP: filtered fall -> LOW. Width reaches T_IDLE -> IDLE.
//   - frame_err_o pulses if bit count != 0.
//   - No error at count 0.
// Word assembly:
// - Shift right, new bit into MSB, so the first bit lands in bit 0 after DATA_W shifts.
// - Bit count wraps to 0 on the DATA_W-th bit; the word completes that cycle.
// - m_valid_o rises the cycle after the completing filtered rise.
// Output handshake:
// - m_data_o is stable while m_valid_o = 1.
// - m_valid_o & m_ready_i clears m_valid_o next cycle.
// - Completion with m_valid_o = 0, or with m_valid_o & m_ready_i in the same cycle:
//   load the new word, m_valid_o = 1.
// - Completion with m_valid_o & ~m_ready_i: new word dropped, overrun_o pulse, old word kept.
// Simultaneous events: frame_err_o and overrun_o never fire for the same pulse. Reset has priority over everything.
// TESTING (DATA_W=8 FILT=3 T_ONE_MAX=8 T_ZERO_MAX=32 T_RESET_MIN=64 T_IDLE=48)
// Byte 0xA5 LSB first (1 = 4-cycle low, 0 = 20-cycle low, 10-cycle gaps), m_ready_i=1 -> m_valid_o for 1 cycle, m_data_o=0xA5, no error pulses.
// 2-cycle low glitch in IDLE and in GAP -> line_lvl_o stays 1, state and bit count unchanged.
// 3 bits, then 40-cycle low -> frame_err_o pulse 1 cycle after filtered rise; next byte 0x3C decodes correctly.
// 5 bits, then 70-cycle low -> bus_reset_o pulses once at filtered-low width 64, no m_valid_o; following byte 0xFF decodes.
// Bytes 0x11, 0x22 with m_ready_i=0 -> overrun_o pulse at 2nd completion; m_data_o stays 0x11 until accepted.
// rst high mid-frame after 4 bits -> all outputs at reset values; next byte 0x5A is received intact.

Source files
------------

// File: rtl/od_pulse_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : od_pulse_receiver
//  Description : Receive end of a pulled-up open-drain single-wire link.
//                Synchronises and glitch-filters the wired line, measures
//                low/high widths, decodes low-pulse widths into bits
//                (LSB first), assembles words and hands them out over a
//                valid/ready port. Flags framing errors, overruns and
//                bus-reset pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module od_pulse_receiver #(
    parameter int DATA_W      = 8,
    parameter int FILT        = 3,
    parameter int T_ONE_MAX   = 8,
    parameter int T_ZERO_MAX  = 32,
    parameter int T_RESET_MIN = 64,
    parameter int T_IDLE      = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              bus_reset_o,
    output logic              line_lvl_o,
    output logic              busy_o
);

    // Width counter saturates at the larger of the two thresholds it serves.
    localparam int c_WMAX = (T_RESET_MIN > T_IDLE) ? T_RESET_MIN : T_IDLE;
    localparam int c_WW   = $clog2(c_WMAX + 1);
    localparam int c_RW   = (FILT > 1) ? $clog2(FILT) : 1;
    localparam int c_BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_GAP  = 2'd2,
        S_RST  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_s1;
    logic                r_s2;
    logic                r_lvl;
    logic                r_lvl_d;
    logic [c_RW-1:0]     r_run;
    logic [c_WW-1:0]     r_width;
    logic [DATA_W-2:0]   r_shift;
    logic [c_BW-1:0]     r_count;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_ferr;
    logic                r_ovr;

    logic                w_flip;
    logic                w_edge;
    logic                w_rise;
    logic                w_fall;
    logic                w_bit;
    logic [DATA_W-1:0]   w_word;
    logic                w_complete;
    logic                w_shift;
    logic                w_clear;
    logic                w_ferr;
    logic                w_brst;

    // The filtered level flips once FILT consecutive synced samples disagree.
    assign w_flip = (r_s2 != r_lvl) && (r_run == c_RW'(FILT - 1));

    // Edges are acted on one cycle after the filtered level changes, so that
    // r_width still holds the full width of the level that just ended.
    assign w_edge = r_lvl ^ r_lvl_d;
    assign w_rise = r_lvl & ~r_lvl_d;
    assign w_fall = ~r_lvl & r_lvl_d;

    // Short lows are ones, medium lows are zeros; new bits enter at the MSB.
    assign w_bit      = (r_width <= c_WW'(T_ONE_MAX));
    assign w_word     = {w_bit, r_shift};
    assign w_complete = w_shift && (r_count == c_BW'(DATA_W - 1));

    // Two-flop synchroniser followed by the run-length glitch filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_lvl   <= 1'b1;
            r_lvl_d <= 1'b1;
            r_run   <= '0;
        end else begin
            r_s1    <= line_i;
            r_s2    <= r_s1;
            r_lvl_d <= r_lvl;
            if (r_s2 == r_lvl) begin
                r_run <= '0;
            end else if (w_flip) begin
                r_lvl <= r_s2;
                r_run <= '0;
            end else begin
                r_run <= r_run + c_RW'(1);
            end
        end
    end

    // Width counter: cycles elapsed since the filtered level last changed.
    // The edge is seen one cycle after the flip, so it restarts at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_width <= '0;
        end else if (w_edge) begin
            r_width <= c_WW'(1);
        end else if (r_width != c_WW'(c_WMAX)) begin
            r_width <= r_width + c_WW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and per-cycle decode actions.
    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_clear     = 1'b0;
        w_ferr      = 1'b0;
        w_brst      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_LOW;
                end
            end
            S_LOW: begin
                // A reset-length low wins even if the rise lands on the same cycle.
                if (r_width >= c_WW'(T_RESET_MIN)) begin
                    w_brst      = 1'b1;
                    w_clear     = 1'b1;
                    w_state_nxt = S_RST;
                end else if (w_rise) begin
                    if (r_width <= c_WW'(T_ZERO_MAX)) begin
                        w_shift     = 1'b1;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_ferr      = 1'b1;
                        w_clear     = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (r_width >= c_WW'(T_IDLE)) begin
                    w_ferr      = (r_count != '0);
                    w_clear     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                // A fall coinciding with the timeout still starts a new pulse.
                if (w_fall) begin
                    w_state_nxt = S_LOW;
                end
            end
            S_RST: begin
                if (w_fall) begin
                    w_state_nxt = S_LOW;
                end else if (r_lvl) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Word assembly, output holding register and registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            r_ovr  <= 1'b0;

            if (w_clear) begin
                r_shift <= '0;
                r_count <= '0;
            end else if (w_shift) begin
                r_shift <= w_word[DATA_W-1:1];
                r_count <= w_complete ? '0 : r_count + c_BW'(1);
            end

            if (w_complete) begin
                if (!r_valid || m_ready_i) begin
                    r_data  <= w_word;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && m_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign m_data_o    = r_data;
    assign m_valid_o   = r_valid;
    assign frame_err_o = r_ferr;
    assign overrun_o   = r_ovr;
    assign bus_reset_o = w_brst & ~rst;
    assign line_lvl_o  = r_lvl;
    assign busy_o      = (r_state != S_IDLE) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_od_pulse_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_od_pulse_receiver
//  Description : Self-checking bench for od_pulse_receiver. Drives pulse
//                trains on the raw line and checks decoded words and status
//                pulses against a width-rule reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_od_pulse_receiver;

    localparam int DATA_W      = 8;
    localparam int FILT        = 3;
    localparam int T_ONE_MAX   = 8;
    localparam int T_ZERO_MAX  = 32;
    localparam int T_RESET_MIN = 64;
    localparam int T_IDLE      = 48;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              line_i    = 1'b1;
    logic              m_ready_i = 1'b1;
    logic [DATA_W-1:0] m_data_o;
    logic              m_valid_o;
    logic              frame_err_o;
    logic              overrun_o;
    logic              bus_reset_o;
    logic              line_lvl_o;
    logic              busy_o;

    int total = 0;
    int bad   = 0;

    od_pulse_receiver #(
        .DATA_W      (DATA_W),
        .FILT        (FILT),
        .T_ONE_MAX   (T_ONE_MAX),
        .T_ZERO_MAX  (T_ZERO_MAX),
        .T_RESET_MIN (T_RESET_MIN),
        .T_IDLE      (T_IDLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .line_i      (line_i),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .bus_reset_o (bus_reset_o),
        .line_lvl_o  (line_lvl_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Monitor: counts status pulses and records accepted words and edge times.
    int         cyc = 0;
    int         n_ferr = 0, n_ovr = 0, n_brst = 0, n_vcyc = 0, n_low = 0;
    int         rise_cyc = 0, fall_cyc = 0, ferr_cyc = 0, brst_cyc = 0, vrise_cyc = 0;
    logic       lvl_prev = 1'b1;
    logic       vld_prev = 1'b0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (frame_err_o) begin n_ferr++; ferr_cyc = cyc; end
            if (overrun_o)   n_ovr++;
            if (bus_reset_o) begin n_brst++; brst_cyc = cyc; end
            if (m_valid_o)   n_vcyc++;
            if (m_valid_o && !vld_prev) vrise_cyc = cyc;
            if (m_valid_o && m_ready_i) rx_q.push_back(m_data_o);
            if (line_lvl_o && !lvl_prev) rise_cyc = cyc;
            if (!line_lvl_o && lvl_prev) fall_cyc = cyc;
            if (!line_lvl_o) n_low++;
        end
        lvl_prev = line_lvl_o;
        vld_prev = m_valid_o;
    end

    // Reference model: applies the width rules to each (low, high) pair.
    int         mcnt = 0;
    logic [7:0] mword = 8'h00;
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    int         exp_brst = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_ferr = 0;
        exp_brst = 0;
        mcnt     = 0;
    endtask

    task automatic pulse(input int lw, input int hw);
        line_i = 1'b0;
        tick(lw);
        line_i = 1'b1;
        tick(hw);
        if (lw >= T_RESET_MIN) begin
            exp_brst++;
            mcnt = 0;
        end else if (lw > T_ZERO_MAX) begin
            exp_ferr++;
            mcnt = 0;
        end else begin
            mword[mcnt] = (lw <= T_ONE_MAX);
            mcnt++;
            if (mcnt == DATA_W) begin
                exp_q.push_back(mword);
                mcnt = 0;
            end
            if (hw >= T_IDLE && mcnt != 0) begin
                exp_ferr++;
                mcnt = 0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input int last_hw);
        for (int i = 0; i < 8; i++) begin
            pulse(v[i] ? 4 : 20, (i == 7) ? last_hw : 10);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(5);
        total++; if (line_lvl_o !== 1'b1) begin bad++; $display("FAIL reset_lvl: got %b want 1", line_lvl_o); end
        total++; if (m_data_o !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", m_data_o); end
        total++; if (m_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", m_valid_o); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
        total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b want 0", overrun_o); end
        total++; if (bus_reset_o !== 1'b0) begin bad++; $display("FAIL reset_brst: got %b want 0", bus_reset_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        rst = 1'b0;
        tick(5);
    endtask

    task automatic test_byte_a5();
        int q0, f0, o0, b0, v0;
        logic [7:0] w;
        model_clear();
        q0 = rx_q.size(); f0 = n_ferr; o0 = n_ovr; b0 = n_brst; v0 = n_vcyc;
        send_byte(8'hA5, 60);
        w = (rx_q.size() > q0) ? rx_q[q0] : 8'hxx;
        total++; if (rx_q.size() - q0 != exp_q.size()) begin bad++; $display("FAIL a5_count: got %0d want %0d", rx_q.size() - q0, exp_q.size()); end
        total++; if (w !== 8'hA5) begin bad++; $display("FAIL a5_data: got %h want a5", w); end
        total++; if (n_vcyc - v0 != 1) begin bad++; $display("FAIL a5_valid_len: got %0d want 1", n_vcyc - v0); end
        total++; if (vrise_cyc - rise_cyc != 1) begin bad++; $display("FAIL a5_valid_lat: got %0d want 1", vrise_cyc - rise_cyc); end
        total++; if (n_ferr - f0 != exp_ferr) begin bad++; $display("FAIL a5_ferr: got %0d want %0d", n_ferr - f0, exp_ferr); end
        total++; if (n_ovr - o0 != 0) begin bad++; $display("FAIL a5_ovr: got %0d want 0", n_ovr - o0); end
        total++; if (n_brst - b0 != 0) begin bad++; $display("FAIL a5_brst: got %0d want 0", n_brst - b0); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL a5_busy_end: got %b want 0", busy_o); end
    endtask

    task automatic test_glitch();
        int q0, f0, l0;
        logic [7:0] v;
        logic [7:0] w;
        v = 8'h96;
        model_clear();
        q0 = rx_q.size(); f0 = n_ferr; l0 = n_low;
        line_i = 1'b0; tick(2); line_i = 1'b1; tick(12);
        total++; if (n_low - l0 != 0) begin bad++; $display("FAIL glitch_idle_lvl: got %0d low cycles want 0", n_low - l0); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL glitch_idle_busy: got %b want 0", busy_o); end
        for (int i = 0; i < 3; i++) pulse(v[i] ? 4 : 20, 10);
        l0 = n_low;
        line_i = 1'b0; tick(2); line_i = 1'b1; tick(10);
        total++; if (n_low - l0 != 0) begin bad++; $display("FAIL glitch_gap_lvl: got %0d low cycles want 0", n_low - l0); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL glitch_gap_busy: got %b want 1", busy_o); end
        for (int i = 3; i < 8; i++) pulse(v[i] ? 4 : 20, (i == 7) ? 60 : 10);
        w = (rx_q.size() > q0) ? rx_q[q0] : 8'hxx;
        total++; if (w !== exp_q[0]) begin bad++; $display("FAIL glitch_data: got %h want %h", w, exp_q[0]); end
        total++; if (n_ferr - f0 != exp_ferr) begin bad++; $display("FAIL glitch_ferr: got %0d want %0d", n_ferr - f0, exp_ferr); end
    endtask

    task automatic test_frame_err();
        int q0, f0;
        logic [7:0] w;
        model_clear();
        q0 = rx_q.size(); f0 = n_ferr;
        for (int i = 0; i < 3; i++) pulse(4, 10);
        pulse(40, 60);
        total++; if (n_ferr - f0 != 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", n_ferr - f0); end
        total++; if (ferr_cyc - rise_cyc != 1) begin bad++; $display("FAIL ferr_lat: got %0d want 1", ferr_cyc - rise_cyc); end
        total++; if (rx_q.size() != q0) begin bad++; $display("FAIL ferr_noword: got %0d want 0", rx_q.size() - q0); end
        send_byte(8'h3C, 60);
        w = (rx_q.size() > q0) ? rx_q[q0] : 8'hxx;
        total++; if (w !== 8'h3C) begin bad++; $display("FAIL ferr_next_data: got %h want 3c", w); end
        total++; if (n_ferr - f0 != exp_ferr) begin bad++; $display("FAIL ferr_total: got %0d want %0d", n_ferr - f0, exp_ferr); end
    endtask

    task automatic test_bus_reset();
        int q0, f0, b0;
        logic [7:0] w;
        model_clear();
        q0 = rx_q.size(); f0 = n_ferr; b0 = n_brst;
        for (int i = 0; i < 5; i++) pulse(20, 10);
        pulse(70, 60);
        total++; if (n_brst - b0 != 1) begin bad++; $display("FAIL brst_count: got %0d want 1", n_brst - b0); end
        total++; if (brst_cyc - fall_cyc != T_RESET_MIN) begin bad++; $display("FAIL brst_width: got %0d want %0d", brst_cyc - fall_cyc, T_RESET_MIN); end
        total++; if (rx_q.size() != q0) begin bad++; $display("FAIL brst_noword: got %0d want 0", rx_q.size() - q0); end
        send_byte(8'hFF, 60);
        w = (rx_q.size() > q0) ? rx_q[q0] : 8'hxx;
        total++; if (w !== 8'hFF) begin bad++; $display("FAIL brst_next_data: got %h want ff", w); end
        total++; if (n_ferr - f0 != exp_ferr) begin bad++; $display("FAIL brst_ferr: got %0d want %0d", n_ferr - f0, exp_ferr); end
    endtask

    task automatic test_overrun();
        int q0, f0, o0;
        logic [7:0] w;
        model_clear();
        q0 = rx_q.size(); f0 = n_ferr; o0 = n_ovr;
        m_ready_i = 1'b0;
        send_byte(8'h11, 10);
        send_byte(8'h22, 60);
        total++; if (n_ovr - o0 != 1) begin bad++; $display("FAIL ovr_count: got %0d want 1", n_ovr - o0); end
        total++; if (n_ferr - f0 != 0) begin bad++; $display("FAIL ovr_ferr: got %0d want 0", n_ferr - f0); end
        total++; if (m_valid_o !== 1'b1) begin bad++; $display("FAIL ovr_valid_held: got %b want 1", m_valid_o); end
        total++; if (m_data_o !== 8'h11) begin bad++; $display("FAIL ovr_data_held: got %h want 11", m_data_o); end
        m_ready_i = 1'b1;
        tick(1);
        w = (rx_q.size() > q0) ? rx_q[q0] : 8'hxx;
        total++; if (w !== 8'h11) begin bad++; $display("FAIL ovr_accept: got %h want 11", w); end
        total++; if (m_valid_o !== 1'b0) begin bad++; $display("FAIL ovr_valid_clr: got %b want 0", m_valid_o); end
        tick(5);
    endtask

    task automatic test_random();
        int q0, f0, o0, b0, n, lw, hw, r;
        logic [7:0] w;
        for (int round = 0; round < 8; round++) begin
            model_clear();
            q0 = rx_q.size(); f0 = n_ferr; o0 = n_ovr; b0 = n_brst;
            n = $urandom_range(1, 20);
            for (int p = 0; p < n; p++) begin
                r = $urandom_range(0, 29);
                if (r == 0)      lw = $urandom_range(T_ZERO_MAX + 1, T_RESET_MIN - 1);
                else if (r == 1) lw = $urandom_range(T_RESET_MIN, T_RESET_MIN + 8);
                else if (r == 2) lw = T_ONE_MAX;
                else if (r == 3) lw = T_ONE_MAX + 1;
                else if (r == 4) lw = T_ZERO_MAX;
                else if (r == 5) lw = T_ZERO_MAX + 1;
                else             lw = $urandom_range(FILT, T_ZERO_MAX);
                if (p == n - 1)                       hw = 60;
                else if ($urandom_range(0, 14) == 0)  hw = $urandom_range(T_IDLE, T_IDLE + 6);
                else                                  hw = $urandom_range(FILT, T_IDLE - 8);
                pulse(lw, hw);
            end
            total++; if (rx_q.size() - q0 != exp_q.size()) begin bad++; $display("FAIL rnd%0d_count: got %0d want %0d", round, rx_q.size() - q0, exp_q.size()); end
            for (int k = 0; k < exp_q.size(); k++) begin
                w = (rx_q.size() > q0 + k) ? rx_q[q0 + k] : 8'hxx;
                total++; if (w !== exp_q[k]) begin bad++; $display("FAIL rnd%0d_word%0d: got %h want %h", round, k, w, exp_q[k]); end
            end
            total++; if (n_ferr - f0 != exp_ferr) begin bad++; $display("FAIL rnd%0d_ferr: got %0d want %0d", round, n_ferr - f0, exp_ferr); end
            total++; if (n_brst - b0 != exp_brst) begin bad++; $display("FAIL rnd%0d_brst: got %0d want %0d", round, n_brst - b0, exp_brst); end
            total++; if (n_ovr - o0 != 0) begin bad++; $display("FAIL rnd%0d_ovr: got %0d want 0", round, n_ovr - o0); end
        end
    endtask

    task automatic test_midframe_reset();
        int q0, f0;
        logic [7:0] w;
        model_clear();
        for (int i = 0; i < 4; i++) pulse(4, 10);
        rst = 1'b1;
        tick(3);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mrst_busy: got %b want 0", busy_o); end
        total++; if (m_valid_o !== 1'b0) begin bad++; $display("FAIL mrst_valid: got %b want 0", m_valid_o); end
        total++; if (m_data_o !== 8'h00) begin bad++; $display("FAIL mrst_data: got %h want 00", m_data_o); end
        total++; if (line_lvl_o !== 1'b1) begin bad++; $display("FAIL mrst_lvl: got %b want 1", line_lvl_o); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL mrst_ferr: got %b want 0", frame_err_o); end
        rst = 1'b0;
        tick(5);
        model_clear();
        q0 = rx_q.size(); f0 = n_ferr;
        send_byte(8'h5A, 60);
        w = (rx_q.size() > q0) ? rx_q[q0] : 8'hxx;
        total++; if (rx_q.size() - q0 != 1) begin bad++; $display("FAIL mrst_count: got %0d want 1", rx_q.size() - q0); end
        total++; if (w !== 8'h5A) begin bad++; $display("FAIL mrst_data_next: got %h want 5a", w); end
        total++; if (n_ferr - f0 != 0) begin bad++; $display("FAIL mrst_ferr_next: got %0d want 0", n_ferr - f0); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_byte_a5();
        test_glitch();
        test_frame_err();
        test_bus_reset();
        test_overrun();
        test_random();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
